// File: rtl/rf_pipe_pkg.sv
// rf_pipe_pkg: shared register-file pipeline types, forward-select codes and helpers
package rf_pipe_pkg;
   localparam int AW = 5;
   localparam logic [1:0] FWD_IDEX = 2'b00;
   localparam logic [1:0] FWD_MEM  = 2'b01;
   localparam logic [1:0] FWD_WB   = 2'b10;
   typedef struct packed {
      logic [AW-1:0] rd;
      logic          we;
      logic          ld;
   } stage_tag_t;
   // x0 is hardwired, so a write to it is never a real producer
   function automatic logic writes(input logic we, input logic [AW-1:0] rd);
      return we && (rd != '0);
   endfunction
endpackage

// File: rtl/rf_fwd_sel.sv
// rf_fwd_sel: per-operand EX forwarding priority selector, youngest producer wins
module rf_fwd_sel
   import rf_pipe_pkg::*;
(
   input  logic          use_rs,
   input  logic [AW-1:0] rs,
   input  stage_tag_t    mem,
   input  logic          wb_we,
   input  logic [AW-1:0] wb_rd,
   output logic [1:0]    sel
);
   // loads in MEM have no data yet; the load-use stall makes the consumer meet them in WB
   assign sel = (use_rs && writes(mem.we, mem.rd) && mem.rd == rs && !mem.ld) ? FWD_MEM :
                (use_rs && writes(wb_we, wb_rd) && wb_rd == rs)              ? FWD_WB  : FWD_IDEX;
endmodule

// File: rtl/rf_hazard_ctrl.sv
// rf_hazard_ctrl: register-file hazard, forwarding, bypass and stall/flush control
module rf_hazard_ctrl
   import rf_pipe_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [AW-1:0]    id_rs1,
   input  logic [AW-1:0]    id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [AW-1:0]    id_rd,
   input  logic             id_regwrite,
   input  logic             id_memread,
   input  logic             ex_branch_taken,
   input  logic             freeze,
   output logic             stall_ifid,
   output logic             bubble_idex,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             id_byp1,
   output logic             id_byp2,
   output logic             wb_we,
   output logic [AW-1:0]    wb_rd,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);
   stage_tag_t    ex_t, mem_t;
   logic [AW-1:0] ex_rs1, ex_rs2;
   logic          ex_use1, ex_use2, lu, fl, wb_wr;
   assign lu = id_valid && ex_t.we && ex_t.ld && ex_t.rd != '0 &&
               ((id_use_rs1 && id_rs1 == ex_t.rd) || (id_use_rs2 && id_rs2 == ex_t.rd));
   assign fl = ex_branch_taken;
   // a flushed instruction is killed anyway, so it never needs to be held
   assign stall_ifid  = freeze | (lu & ~fl);
   assign bubble_idex = ~freeze & (lu | fl | ~id_valid);
   assign wb_wr   = writes(wb_we, wb_rd);
   assign id_byp1 = id_valid && id_use_rs1 && wb_wr && wb_rd == id_rs1;
   assign id_byp2 = id_valid && id_use_rs2 && wb_wr && wb_rd == id_rs2;
   rf_fwd_sel u_fwd_a (
      .use_rs (ex_use1),
      .rs     (ex_rs1),
      .mem    (mem_t),
      .wb_we  (wb_we),
      .wb_rd  (wb_rd),
      .sel    (fwd_a)
   );
   rf_fwd_sel u_fwd_b (
      .use_rs (ex_use2),
      .rs     (ex_rs2),
      .mem    (mem_t),
      .wb_we  (wb_we),
      .wb_rd  (wb_rd),
      .sel    (fwd_b)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_t        <= '0;
         mem_t       <= '0;
         ex_rs1      <= '0;
         ex_rs2      <= '0;
         ex_use1     <= 1'b0;
         ex_use2     <= 1'b0;
         wb_we       <= 1'b0;
         wb_rd       <= '0;
         stall_count <= '0;
         flush_count <= '0;
      end else if (!freeze) begin
         wb_we   <= mem_t.we;
         wb_rd   <= mem_t.rd;
         mem_t   <= ex_t;
         ex_t    <= bubble_idex ? '0 : stage_tag_t'{rd: id_rd, we: id_regwrite, ld: id_memread};
         ex_rs1  <= bubble_idex ? '0 : id_rs1;
         ex_rs2  <= bubble_idex ? '0 : id_rs2;
         ex_use1 <= ~bubble_idex & id_use_rs1;
         ex_use2 <= ~bubble_idex & id_use_rs2;
         if (lu && !fl && !(&stall_count))
            stall_count <= stall_count + CNT_W'(1);
         if (fl && !(&flush_count))
            flush_count <= flush_count + CNT_W'(1);
      end
   end
endmodule
